// File: rtl/sudoku_top.sv
// Sudoku game controller: 81-cell board, cursor, digit select, conflict-checked placement.
// Button events commit on the edge they are seen; seven-segment outputs follow one cycle later.
module sudoku_top (
  input  logic       clk,
  input  logic       reset,
  input  logic       original_up_button,
  input  logic       original_down_button,
  input  logic       original_left_button,
  input  logic       original_right_button,
  input  logic       original_start_button,
  input  logic       original_a_button,
  input  logic       original_b_button,
  output logic       error,
  output logic [6:0] d0,
  output logic [6:0] d1,
  output logic [6:0] d2,
  output logic [6:0] d3,
  output logic [6:0] d4,
  output logic [6:0] d5,
  output logic [6:0] d6,
  output logic [6:0] d7
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] WIN  = 2'd2;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [1:0] state;
  logic [3:0] board [0:80];
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] digit;
  logic [6:0] count;

  // Button order sets event priority: start, A, B, up, down, left, right.
  logic [6:0] pressed;
  logic [6:0] prev;
  logic [6:0] rise;
  logic [6:0] sel;

  logic [6:0] idx;
  logic [3:0] cur_cell;
  logic [3:0] row_box;
  logic [3:0] col_box;
  logic       conflict;
  logic [3:0] tens;
  logic [3:0] ones;

  assign pressed = {~original_right_button, ~original_left_button,
                    ~original_down_button,  ~original_up_button,
                    original_b_button, original_a_button, original_start_button};
  assign rise = pressed & ~prev;
  // Isolate the lowest set bit so only the highest-priority event acts.
  assign sel  = rise & (~rise + 7'd1);

  assign idx      = {3'b000, row} * 7'd9 + {3'b000, col};
  assign cur_cell = board[idx];
  assign row_box  = row / 4'd3;
  assign col_box  = col / 4'd3;
  assign tens     = 4'(count / 7'd10);
  assign ones     = 4'(count % 7'd10);

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < 81; i++) begin
      if ((i[6:0] != idx) && (board[i] == digit) &&
          (((i / 9) == int'(row)) || ((i % 9) == int'(col)) ||
           (((i / 27) == int'(row_box)) && (((i % 9) / 3) == int'(col_box)))))
        conflict = 1'b1;
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      error <= 1'b0;
      row   <= 4'd0;
      col   <= 4'd0;
      digit <= 4'd1;
      count <= 7'd0;
      prev  <= 7'd0;
      for (int i = 0; i < 81; i++) board[i] <= 4'd0;
    end else begin
      prev <= pressed;
      case (state)
        IDLE: begin
          if (sel[0]) begin
            state <= PLAY;
            row   <= 4'd0;
            col   <= 4'd0;
            digit <= 4'd1;
            count <= 7'd0;
            error <= 1'b0;
            for (int i = 0; i < 81; i++) board[i] <= 4'd0;
          end
        end
        PLAY: begin
          // A full board takes precedence; any edge seen that cycle is dropped.
          if (count == 7'd81) begin
            state <= WIN;
          end else if (sel[0]) begin
            state <= IDLE;
            error <= 1'b0;
          end else if (sel[1]) begin
            if (cur_cell == digit) begin
              board[idx] <= 4'd0;
              count      <= count - 7'd1;
              error      <= 1'b0;
            end else if (conflict) begin
              error <= 1'b1;
            end else begin
              board[idx] <= digit;
              if (cur_cell == 4'd0) count <= count + 7'd1;
              error <= 1'b0;
            end
          end else if (sel[2]) begin
            digit <= (digit == 4'd9) ? 4'd1 : digit + 4'd1;
            error <= 1'b0;
          end else if (sel[3]) begin
            row   <= (row == 4'd0) ? 4'd8 : row - 4'd1;
            error <= 1'b0;
          end else if (sel[4]) begin
            row   <= (row == 4'd8) ? 4'd0 : row + 4'd1;
            error <= 1'b0;
          end else if (sel[5]) begin
            col   <= (col == 4'd0) ? 4'd8 : col - 4'd1;
            error <= 1'b0;
          end else if (sel[6]) begin
            col   <= (col == 4'd8) ? 4'd0 : col + 4'd1;
            error <= 1'b0;
          end
        end
        WIN: begin
          if (sel[0]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      {d7, d6, d5, d4, d3, d2, d1, d0} <= {8{SEG_DASH}};
    end else begin
      case (state)
        PLAY: begin
          d7 <= seg(row + 4'd1);
          d6 <= seg(col + 4'd1);
          d5 <= SEG_BLANK;
          d4 <= (cur_cell == 4'd0) ? SEG_BLANK : seg(cur_cell);
          d3 <= SEG_BLANK;
          d2 <= seg(digit);
          d1 <= seg(tens);
          d0 <= seg(ones);
        end
        WIN: begin
          {d7, d6, d5, d4, d3, d2} <= {6{SEG_BLANK}};
          d1 <= seg(4'd8);
          d0 <= seg(4'd1);
        end
        default: {d7, d6, d5, d4, d3, d2, d1, d0} <= {8{SEG_DASH}};
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_top.sv
// Bench for sudoku_top: game-level reference model compared every cycle, plus literal display checks.
module tb_sudoku_top;

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] S_0 = 7'b1000000;
  localparam logic [6:0] S_1 = 7'b1111001;
  localparam logic [6:0] S_2 = 7'b0100100;
  localparam logic [6:0] S_8 = 7'b0000000;
  localparam logic [6:0] S_9 = 7'b0010000;

  localparam int B_START = 0, B_A = 1, B_B = 2, B_UP = 3, B_DOWN = 4, B_LEFT = 5, B_RIGHT = 6;
  localparam int G_IDLE = 0, G_PLAY = 1, G_WIN = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] pr = 7'd0;
  logic       error;
  logic [6:0] d0, d1, d2, d3, d4, d5, d6, d7;

  int compared = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sudoku_top dut (
    .clk                  (clk),
    .reset                (reset),
    .original_up_button   (~pr[B_UP]),
    .original_down_button (~pr[B_DOWN]),
    .original_left_button (~pr[B_LEFT]),
    .original_right_button(~pr[B_RIGHT]),
    .original_start_button(pr[B_START]),
    .original_a_button    (pr[B_A]),
    .original_b_button    (pr[B_B]),
    .error                (error),
    .d0                   (d0),
    .d1                   (d1),
    .d2                   (d2),
    .d3                   (d3),
    .d4                   (d4),
    .d5                   (d5),
    .d6                   (d6),
    .d7                   (d7)
  );

  // Reference game model
  int         g_state;
  int         g_board [9][9];
  int         g_r, g_c, g_dig, g_cnt;
  bit         g_err;
  logic [6:0] g_prev;
  logic [6:0] g_ev;
  int         g_first;
  logic [55:0] exp_disp;
  bit         g_valid = 1'b0;

  function automatic logic [6:0] seg(int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  function automatic logic [55:0] model_disp();
    if (g_state == G_PLAY)
      return {seg(g_r + 1), seg(g_c + 1), BLANK,
              (g_board[g_r][g_c] == 0) ? BLANK : seg(g_board[g_r][g_c]),
              BLANK, seg(g_dig), seg(g_cnt / 10), seg(g_cnt % 10)};
    if (g_state == G_WIN)
      return {{6{BLANK}}, seg(8), seg(1)};
    return {8{DASH}};
  endfunction

  function automatic bit used_elsewhere(int r, int c, int v);
    int br, bc;
    for (int k = 0; k < 9; k++) begin
      if (k != c && g_board[r][k] == v) return 1'b1;
      if (k != r && g_board[k][c] == v) return 1'b1;
    end
    br = (r / 3) * 3;
    bc = (c / 3) * 3;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (!((br + i) == r && (bc + j) == c) && g_board[br + i][bc + j] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_board();
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 9; j++) g_board[i][j] = 0;
  endtask

  always @(posedge clk) begin
    exp_disp = model_disp();
    if (!reset) begin
      g_state = G_IDLE; g_err = 1'b0; g_r = 0; g_c = 0; g_dig = 1; g_cnt = 0;
      g_prev = 7'd0;
      clear_board();
      exp_disp = {8{DASH}};
      g_valid = 1'b1;
    end else begin
      g_ev = pr & ~g_prev;
      g_prev = pr;
      g_first = -1;
      for (int i = 6; i >= 0; i--) if (g_ev[i]) g_first = i;
      if (g_state == G_PLAY && g_cnt == 81) begin
        g_state = G_WIN;
      end else if (g_state == G_IDLE) begin
        if (g_first == B_START) begin
          g_state = G_PLAY; clear_board();
          g_r = 0; g_c = 0; g_dig = 1; g_cnt = 0; g_err = 1'b0;
        end
      end else if (g_state == G_WIN) begin
        if (g_first == B_START) g_state = G_IDLE;
      end else begin
        case (g_first)
          B_START: begin g_state = G_IDLE; g_err = 1'b0; end
          B_A: begin
            if (g_board[g_r][g_c] == g_dig) begin
              g_board[g_r][g_c] = 0; g_cnt--; g_err = 1'b0;
            end else if (used_elsewhere(g_r, g_c, g_dig)) begin
              g_err = 1'b1;
            end else begin
              if (g_board[g_r][g_c] == 0) g_cnt++;
              g_board[g_r][g_c] = g_dig; g_err = 1'b0;
            end
          end
          B_B:     begin g_dig = g_dig % 9 + 1; g_err = 1'b0; end
          B_UP:    begin g_r = (g_r + 8) % 9; g_err = 1'b0; end
          B_DOWN:  begin g_r = (g_r + 1) % 9; g_err = 1'b0; end
          B_LEFT:  begin g_c = (g_c + 8) % 9; g_err = 1'b0; end
          B_RIGHT: begin g_c = (g_c + 1) % 9; g_err = 1'b0; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (g_valid) begin
      compared++;
      if (error !== g_err) begin
        failed++;
        $display("FAIL model_error t=%0t: got %b want %b", $time, error, g_err);
      end
      compared++;
      if ({d7, d6, d5, d4, d3, d2, d1, d0} !== exp_disp) begin
        failed++;
        $display("FAIL model_display t=%0t: got %h want %h", $time,
                 {d7, d6, d5, d4, d3, d2, d1, d0}, exp_disp);
      end
    end
  end

  task automatic chk(string name, logic [6:0] act, logic [6:0] want);
    compared++;
    if (act !== want) begin
      failed++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int b);
    @(negedge clk); pr[b] = 1'b1;
    @(negedge clk); pr[b] = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    #400000;
    failed++;
    $display("FAIL watchdog: bench did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $fatal(1, "timeout");
  end

  initial begin
    int cur, t;
    cyc(2);
    reset = 1'b1;
    cyc(5); #1;
    chk("reset_error", {6'b0, error}, 7'd0);
    chk("reset_d0", d0, DASH);
    chk("reset_d7", d7, DASH);

    // Start held for two cycles
    @(negedge clk); pr[B_START] = 1'b1;
    cyc(2); pr[B_START] = 1'b0;
    cyc(1); #1;
    chk("start_d7", d7, S_1);
    chk("start_d6", d6, S_1);
    chk("start_d4", d4, BLANK);
    chk("start_d2", d2, S_1);
    chk("start_d1", d1, S_0);
    chk("start_d0", d0, S_0);

    press(B_A);
    chk("place_d4", d4, S_1);
    chk("place_d0", d0, S_1);
    chk("place_err", {6'b0, error}, 7'd0);
    press(B_A);
    chk("clear_d4", d4, BLANK);
    chk("clear_d0", d0, S_0);

    press(B_A);
    press(B_RIGHT);
    press(B_A);
    chk("reject_err", {6'b0, error}, 7'd1);
    chk("reject_d4", d4, BLANK);
    chk("reject_d0", d0, S_1);
    press(B_B);
    chk("nextdig_d2", d2, S_2);
    chk("nextdig_err", {6'b0, error}, 7'd0);
    press(B_A);
    chk("accept_d0", d0, S_2);
    chk("accept_d4", d4, S_2);

    press(B_LEFT);
    press(B_LEFT);
    chk("wrap_left_d6", d6, S_9);
    press(B_UP);
    chk("wrap_up_d7", d7, S_9);

    // Start and A together: only the abort is taken
    @(negedge clk); pr[B_START] = 1'b1; pr[B_A] = 1'b1;
    @(negedge clk); pr = 7'd0;
    cyc(1); #1;
    chk("abort_d7", d7, DASH);
    chk("abort_d4", d4, DASH);
    chk("abort_err", {6'b0, error}, 7'd0);

    // Reset in the middle of play
    press(B_START);
    press(B_RIGHT);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    cyc(1); #1;
    chk("midreset_d6", d6, DASH);

    // Fill with a known-valid solution
    press(B_START);
    cur = 1;
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) begin
        t = ((r * 3 + r / 3 + c) % 9) + 1;
        while (cur != t) begin
          press(B_B);
          cur = cur % 9 + 1;
        end
        press(B_A);
        if (c < 8) press(B_RIGHT);
        else if (r < 8) begin
          press(B_RIGHT);
          press(B_DOWN);
        end
      end
    end
    chk("full_d1", d1, S_8);
    chk("full_d0", d0, S_1);
    cyc(2); #1;
    chk("win_d7", d7, BLANK);
    chk("win_d2", d2, BLANK);
    chk("win_d1", d1, S_8);
    chk("win_d0", d0, S_1);
    press(B_B);
    chk("win_ignore_b", d0, S_1);
    press(B_START);
    chk("win_exit_d0", d0, DASH);
    chk("win_exit_d7", d7, DASH);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/sudoku_top.md
Name: sudoku_top

Overview:
Top-level controller for a single-player 9x9 Sudoku game on a board with seven push buttons, eight seven-segment digits and one error LED. It holds the 81-cell board, a cursor and a selected digit. It accepts placements only when they do not conflict with the cell's row, column or 3x3 box, and reports progress on the displays. It is the design root; there are no parameters.

Parameters:
none

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-low reset
original_up_button  in  1  cursor up, active-low
original_down_button  in  1  cursor down, active-low
original_left_button  in  1  cursor left, active-low
original_right_button  in  1  cursor right, active-low
original_start_button  in  1  start/abort, active-high
original_a_button  in  1  place/clear, active-high
original_b_button  in  1  next digit, active-high
error  out  1  rejected-placement indicator, active-high
d0..d7  out  7 each  seven-segment digits (d7 leftmost), active-low, bit order {g,f,e,d,c,b,a}

Behaviour:
- Single clock. Reset is synchronous and active-low: when reset==0 at a clk edge, all state is initialised.
- Reset values:
  - state IDLE, error=0, all cells 0 (empty)
  - cursor row=0, col=0, selected digit=1, fill count=0
  - all button history = released
  - d0..d7 = dash (7'b0111111)
- Button events:
  - Each input is converted to a "pressed" level (directions inverted).
  - A previous-pressed register per button gives a one-cycle event on a released->pressed edge.
  - No debounce or synchroniser is required.
- Priority: at most one event is processed per cycle, in the order start > A > B > up > down > left > right. Lower-priority simultaneous events are dropped, and their edges are not retried.
- States: IDLE, PLAY, WIN.
- IDLE:
  - start -> PLAY. The same edge clears the board, sets cursor (0,0), digit=1, count=0 and error=0.
  - Other buttons are ignored.
- PLAY, directions: move the cursor one cell with wrap-around (row 0 up -> row 8; col 8 right -> col 0). Directions clear error.
- PLAY, B: selected digit increments 1..9, with 9 wrapping to 1. B clears error.
- PLAY, A on the cell at the cursor:
  - Cell equals the selected digit: cell cleared to 0, count-1, error=0.
  - Else if the selected digit appears in another cell of the same row, column or 3x3 box (the cell itself is excluded): the cell is unchanged and error=1.
  - Else: cell := digit. If the cell was empty, count+1; error=0.
  - Conflict check is combinational; the result is committed on the same edge as the A event (one-cycle latency to outputs).
- PLAY, start: abort -> IDLE. The board is retained until the next start; error=0.
- count reaching 81 -> WIN on the next cycle.
- WIN: start -> IDLE. All other buttons are ignored.
- The board never contains conflicts, so count==81 means solved.
- error holds its value until the next processed event.
- Displays (registered from state, one-cycle latency):
  - IDLE: all eight digits dash.
  - PLAY:
    - d7 = row+1, d6 = col+1
    - d5 blank (7'b1111111)
    - d4 = cell value, blank if empty
    - d3 blank
    - d2 = selected digit
    - d1 = count tens, d0 = count ones
  - WIN: d7..d2 blank, d1="8", d0="1".
- Digit encodings:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset asserted in any state, mid-operation, returns to the reset values on that edge.

Test Plan:
- Reset low 2 cycles, then release with directions=1 and start/A/B=0 -> error=0, d0..d7 all 7'b0111111, no state change over 5 cycles.
- Start rising edge (held 1 for 2 cycles, then 0) -> PLAY: d7=1111001 ("1"), d6="1", d4 blank, d2="1", d1="0", d0="0".
- A press -> d4="1", count 01 (d0=1111001), error=0. A press again -> cell cleared, d4 blank, count 00.
- Place 1 at (0,0), right, A -> rejected (same row): error=1, d4 blank, count 01. B press -> d2="2", error=0. A -> accepted, count 02.
- Left at col 0 -> d6="9". Up at row 0 -> d7="9". Start and A asserted on the same cycle in PLAY -> only the abort happens: all dashes, board unchanged.
- Fill the board with a valid solution through the button sequence -> count 81, then WIN: d1="8", d0="1", d7..d2 blank. Start -> IDLE.
